// File: rtl/fnd_scan_driver.sv
// Four-digit multiplexed 7-segment driver fed by an external 2-bit scan counter.
// Loads are shadowed and committed at frame wrap so a frame never mixes two values.
module fnd_scan_driver #(
  parameter bit BLANK_LZ   = 1'b1,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [1:0]  sel_i,
  input  logic [15:0] value_i,
  input  logic [3:0]  dp_mask_i,
  input  logic        load_i,
  output logic [3:0]  an_o,
  output logic [6:0]  seg_o,
  output logic        dp_o,
  output logic        err_o
);

  localparam logic [3:0] AN_OFF  = ACTIVE_LOW ? 4'hF : 4'h0;
  localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = ACTIVE_LOW;

  logic [15:0] pend_val_q, pend_val_d;
  logic [3:0]  pend_dp_q, pend_dp_d;
  logic        pend_valid_q, pend_valid_d;
  logic [15:0] disp_val_q, disp_val_d;
  logic [3:0]  disp_dp_q, disp_dp_d;
  logic [1:0]  sel_prev_q;
  logic        err_q, err_d;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;

  logic        wrap, commit;
  logic [3:0]  nibble;
  logic        dp_bit, upper_zero, blank;
  logic [6:0]  seg_hex, seg_raw;
  logic [3:0]  an_raw;
  logic        dp_raw;

  always_comb begin
    wrap         = (sel_prev_q == 2'd3) && (sel_i == 2'd0);
    commit       = wrap && pend_valid_q;
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    disp_val_d   = disp_val_q;
    disp_dp_d    = disp_dp_q;
    // Commit reads the old pending contents even if a new load lands this cycle.
    if (commit) begin
      disp_val_d = pend_val_q;
      disp_dp_d  = pend_dp_q;
    end
    if (load_i) begin
      pend_val_d   = value_i;
      pend_dp_d    = dp_mask_i;
      pend_valid_d = 1'b1;
    end else if (commit) begin
      pend_valid_d = 1'b0;
    end
    err_d = err_q | (sel_i != (sel_prev_q + 2'd1));
  end

  always_comb begin
    nibble = disp_val_d[{sel_i, 2'b00} +: 4];
    dp_bit = disp_dp_d[sel_i];
    case (nibble)
      4'h0: seg_hex = 7'h3F;
      4'h1: seg_hex = 7'h06;
      4'h2: seg_hex = 7'h5B;
      4'h3: seg_hex = 7'h4F;
      4'h4: seg_hex = 7'h66;
      4'h5: seg_hex = 7'h6D;
      4'h6: seg_hex = 7'h7D;
      4'h7: seg_hex = 7'h07;
      4'h8: seg_hex = 7'h7F;
      4'h9: seg_hex = 7'h6F;
      4'hA: seg_hex = 7'h77;
      4'hB: seg_hex = 7'h7C;
      4'hC: seg_hex = 7'h39;
      4'hD: seg_hex = 7'h5E;
      4'hE: seg_hex = 7'h79;
      default: seg_hex = 7'h71;
    endcase
    // Leading-zero test: the active nibble and every nibble above it are zero.
    upper_zero = 1'b1;
    for (int j = 0; j < 4; j++) begin
      if ((j >= int'(sel_i)) && (disp_val_d[4*j +: 4] != 4'h0)) upper_zero = 1'b0;
    end
    blank   = BLANK_LZ && (sel_i != 2'd0) && upper_zero && !dp_bit;
    an_raw  = blank ? 4'h0 : (4'b0001 << sel_i);
    seg_raw = blank ? 7'h00 : seg_hex;
    dp_raw  = !blank && dp_bit;
    an_d    = ACTIVE_LOW ? ~an_raw : an_raw;
    seg_d   = ACTIVE_LOW ? ~seg_raw : seg_raw;
    dp_d    = ACTIVE_LOW ? ~dp_raw : dp_raw;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pend_val_q   <= 16'h0000;
      pend_dp_q    <= 4'h0;
      pend_valid_q <= 1'b0;
      disp_val_q   <= 16'h0000;
      disp_dp_q    <= 4'h0;
      sel_prev_q   <= 2'd3;
      err_q        <= 1'b0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
      dp_q         <= DP_OFF;
    end else begin
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      sel_prev_q   <= sel_i;
      err_q        <= err_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
    end
  end

  assign an_o  = an_q;
  assign seg_o = seg_q;
  assign dp_o  = dp_q;
  assign err_o = err_q;

endmodule

// File: tb/tb_fnd_scan_driver.sv
// Self-checking bench for fnd_scan_driver: directed scenarios plus random loads
// against a frame-level reference model of the display.
module tb_fnd_scan_driver;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic [1:0]  sel_i = 2'd0;
  logic [15:0] value_i = 16'h0;
  logic [3:0]  dp_mask_i = 4'h0;
  logic        load_i = 1'b0;
  logic [3:0]  an_o;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic        err_o;

  int total = 0;
  int bad = 0;
  int cnt = 0;

  // reference model state
  int          m_pend_val, m_pend_dp, m_disp_val, m_disp_dp, m_prev;
  bit          m_pend_v, m_err;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic [6:0]  seg_tab [16];

  fnd_scan_driver #(.BLANK_LZ(1'b1), .ACTIVE_LOW(1'b1)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .sel_i(sel_i), .value_i(value_i),
    .dp_mask_i(dp_mask_i), .load_i(load_i), .an_o(an_o), .seg_o(seg_o),
    .dp_o(dp_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit commit, blank;
    int nib, upper;
    if (reset_i) begin
      m_pend_val = 0; m_pend_dp = 0; m_pend_v = 0;
      m_disp_val = 0; m_disp_dp = 0; m_prev = 3; m_err = 0;
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      return;
    end
    commit = (m_prev == 3) && (sel_i == 0) && m_pend_v;
    if (commit) begin
      m_disp_val = m_pend_val;
      m_disp_dp  = m_pend_dp;
    end
    if (load_i) begin
      m_pend_val = value_i; m_pend_dp = dp_mask_i; m_pend_v = 1;
    end else if (commit) begin
      m_pend_v = 0;
    end
    if (int'(sel_i) != (m_prev + 1) % 4) m_err = 1;
    m_prev = sel_i;
    upper = m_disp_val >> (4 * int'(sel_i));
    nib   = upper % 16;
    blank = (sel_i != 0) && (upper == 0) && (((m_disp_dp >> int'(sel_i)) % 2) == 0);
    if (blank) begin
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    end else begin
      e_an  = 4'hF ^ (4'd1 << sel_i);
      e_seg = ~seg_tab[nib];
      e_dp  = !((m_disp_dp >> int'(sel_i)) % 2);
    end
  endtask

  // one clock with given inputs; model and DUT compared #1 after the edge
  task automatic tick(input bit rst, input logic [1:0] s, input bit ld,
                      input logic [15:0] v, input logic [3:0] dm);
    reset_i = rst; sel_i = s; load_i = ld; value_i = v; dp_mask_i = dm;
    @(posedge clk_i);
    model_step();
    #1;
    check("an", 32'(an_o), 32'(e_an));
    check("seg", 32'(seg_o), 32'(e_seg));
    check("dp", 32'(dp_o), 32'(e_dp));
    check("err", 32'(err_o), 32'(m_err));
  endtask

  // normal counter step
  task automatic step(input bit ld, input logic [15:0] v, input logic [3:0] dm);
    tick(1'b0, cnt[1:0], ld, v, dm);
    cnt = (cnt + 1) % 4;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      tick(1'b1, 2'd0, 1'b0, 16'h0, 4'h0);
      check("rst_an", 32'(an_o), 32'hF);
      check("rst_seg", 32'(seg_o), 32'h7F);
      check("rst_dp", 32'(dp_o), 32'h1);
      check("rst_err", 32'(err_o), 32'h0);
    end
    cnt = 0;
  endtask

  initial begin
    seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    do_reset(3);

    // first frame after reset: "0" on digit 0, rest blank
    step(0, 0, 0);
    check("f0_an0", 32'(an_o), 32'hE);
    check("f0_seg0", 32'(seg_o), 32'h40);
    for (int i = 1; i < 4; i++) begin
      step(0, 0, 0);
      check("f0_blank", 32'(an_o), 32'hF);
    end

    // load 12AF at sel=1, visible only after the next wrap
    step(0, 0, 0);
    step(1, 16'h12AF, 4'h0);
    step(0, 0, 0);
    check("pre_wrap", 32'(seg_o), 32'h7F);
    step(0, 0, 0);
    begin
      logic [3:0] an_exp [4];
      logic [6:0] seg_exp [4];
      an_exp  = '{4'hE, 4'hD, 4'hB, 4'h7};
      seg_exp = '{7'h0E, 7'h08, 7'h24, 7'h79};
      for (int i = 0; i < 4; i++) begin
        step(0, 0, 0);
        check("h12AF_an", 32'(an_o), 32'(an_exp[i]));
        check("h12AF_seg", 32'(seg_o), 32'(seg_exp[i]));
      end
    end

    // tearing / overwrite: 2222 wins
    step(0, 0, 0); step(0, 0, 0);
    step(1, 16'h1111, 4'h0);
    step(1, 16'h2222, 4'h0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0);
      check("ovw_seg", 32'(seg_o), 32'h24);
    end

    // simultaneous load and wrap
    step(0, 0, 0); step(0, 0, 0);
    step(1, 16'h0005, 4'h0);
    step(0, 0, 0);
    step(1, 16'h0006, 4'h0);
    check("sim5_seg", 32'(seg_o), 32'h12);
    for (int i = 1; i < 4; i++) begin
      step(0, 0, 0);
      check("sim5_blank", 32'(an_o), 32'hF);
    end
    step(0, 0, 0);
    check("sim6_seg", 32'(seg_o), 32'h02);
    step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);

    // decimal point keeps a leading zero digit lit
    step(0, 0, 0);
    step(1, 16'h0007, 4'b0100);
    step(0, 0, 0); step(0, 0, 0);
    step(0, 0, 0);
    check("dp7_seg0", 32'(seg_o), 32'h78);
    step(0, 0, 0);
    check("dp7_an1", 32'(an_o), 32'hF);
    step(0, 0, 0);
    check("dp7_an2", 32'(an_o), 32'hB);
    check("dp7_seg2", 32'(seg_o), 32'h40);
    check("dp7_dp2", 32'(dp_o), 32'h0);
    step(0, 0, 0);
    check("dp7_an3", 32'(an_o), 32'hF);

    // random loads with a free-running counter
    for (int i = 0; i < 400; i++) begin
      logic [15:0] v;
      v = 16'($urandom);
      case ($urandom_range(0, 3))
        0: v = v & 16'h000F;
        1: v = v & 16'h00FF;
        default: ;
      endcase
      step($urandom_range(0, 3) == 0, v, 4'($urandom_range(0, 15) & ($urandom_range(0, 1) ? 15 : 0)));
    end
    check("err_clean", 32'(err_o), 32'h0);

    // sequence skip 0 -> 2
    while (cnt != 0) step(0, 0, 0);
    step(0, 0, 0);
    tick(1'b0, 2'd2, 1'b0, 0, 0);
    check("skip_err", 32'(err_o), 32'h1);
    cnt = 3;
    for (int i = 0; i < 12; i++) step($urandom_range(0, 3) == 0, 16'($urandom), 4'h0);
    check("err_sticky", 32'(err_o), 32'h1);

    // mid-operation reset clears everything
    do_reset(2);
    step(0, 0, 0);
    check("post_rst_seg", 32'(seg_o), 32'h40);
    step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fnd_scan_driver.md
# fnd_scan_driver

Downstream consumer of the 2-bit free-running digit counter. Takes the counter's 2-bit phase and a 16-bit hex value and drives a 4-digit multiplexed 7-segment display. Loads are held in a shadow buffer and committed only at a scan-frame boundary, so a frame never mixes digits from two values. Output is registered, supports leading-zero blanking, and raises a sticky error flag if the phase input does not advance by exactly +1 per clock.

## Interface
- BLANK_LZ, default 1: 1 = blank leading zero digits; 0 = show all four digits.
- ACTIVE_LOW, default 1: 1 = an/seg/dp outputs are active-low; 0 = active-high.

- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high; shares the counter's reset.
- sel  input  2  digit phase from the 2-bit up counter (0→1→2→3→0).
- value  input  16  hex value; digit k = value[4k+3:4k], digit 0 is rightmost.
- dp_mask  input  4  decimal point per digit; bit k lights digit k's point.
- load  input  1  single-cycle strobe; captures value and dp_mask.
- an  output  4  digit enables, one-hot on sel (polarity per ACTIVE_LOW).
- seg  output  7  segments {g,f,e,d,c,b,a} (polarity per ACTIVE_LOW).
- dp  output  1  decimal point of the active digit.
- err  output  1  sticky phase-sequence error.

## Operation
- **Pending buffer.** pend_val[15:0], pend_dp[3:0] and pend_valid.
  - load=1: capture value/dp_mask and set pend_valid.
  - A load while already pending overwrites the buffer; the latest load wins.
- **Display buffer.** disp_val[15:0] and disp_dp[3:0].
  - Frame boundary (wrap): sel_prev==3 and sel==0.
  - On a wrap with pend_valid=1, copy pend → disp.
  - pend_valid clears on commit unless load is also 1 that cycle.
- **Simultaneous load and wrap.**
  - If pend_valid=1: the old pend contents commit, and the new value becomes pending (pend_valid stays 1).
  - If pend_valid=0: nothing commits; the new value becomes pending and commits at the next wrap.
- **sel_prev.** Registered copy of sel; reset value 3, so the first sel=0 after reset is a wrap.
- **Sequence check.**
  - Each cycle, if sel != (sel_prev+1) mod 4, set err=1.
  - err clears only on reset.
  - A held sel, a skip, or a backward step all set err.
- **Decode.**
  - nibble = disp_val[4·sel+3 : 4·sel].
  - Standard hex codes, {g..a} active-high form: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- **Blanking (BLANK_LZ=1).**
  - Digit k≥1 is blank when nibbles 3 down to k of disp_val are all zero.
  - Digit 0 is never blank.
  - A blank digit has an deasserted, all segments off, and dp off.
  - A digit whose dp bit is set is never blanked; it shows normally.
- **Polarity (ACTIVE_LOW=1).** an, seg and dp are all inverted.
- **Decode uses post-commit data.** The decode path reads disp_val and disp_dp as written at the clock edge that begins the frame, so a wrap cycle's digit 0 already shows the new value (see Timing).

## Timing
- **Reset values.**
  - Outputs: an all off (4'hF at ACTIVE_LOW=1), seg all off (7'h7F), dp off (1), err=0.
  - Internal: disp_val=0, disp_dp=0, pend_valid=0, sel_prev=3.
- **Output latency.** an/seg/dp are registered, with one cycle of latency from sel.
  - Outputs at edge N+1 reflect sel sampled at edge N and the disp contents after any commit at edge N.
  - Implementation: decode from the next-state disp values.
- **Load to display.**
  - A load accepted at edge L commits at the first wrap edge W > L.
  - The first output showing the new value appears at edge W+1, on digit 0.
  - Worst case: 4 cycles from load to commit, plus 1 output cycle.
- **Error flag.** err rises on the edge after the offending sel is sampled.
- **Reset mid-operation.**
  - Pending and displayed data are discarded and outputs return to reset values on the next edge.
  - The first post-reset frame starts when sel=0.

## Test plan
- **Reset.** Hold reset 3 cycles with ACTIVE_LOW=1 → an=F, seg=7F, dp=1, err=0. Release with the counter → frame 0 shows digit 0 = "0" (seg=40, an=E); digits 1–3 are blank (an=F).
- **Load and commit.**
  - Stimulus: load value=16'h12AF at sel=1.
  - Before the next wrap, the display is unchanged.
  - After the wrap, the per-digit outputs for an=E/D/B/7 are seg = 0E(F), 08(A), 24(2), 79(1).
- **Tearing and overwrite.**
  - Stimulus: load 16'h1111 at sel=2, then 16'h2222 at sel=3 in the same frame.
  - Only 2222 is ever displayed, starting at digit 0 of the next frame; 1111 never appears.
- **Simultaneous load and wrap.**
  - Stimulus: load 16'h0005 at sel=2; load 16'h0006 on the wrap cycle (sel_prev=3, sel=0).
  - One frame shows "5" with digits 1–3 blank.
  - The following frame shows "6".
- **Decimal point and blanking.**
  - Stimulus: value=16'h0007 with dp_mask=4'b0100.
  - Digit 2 is lit with seg=40 (0) and dp=0; digit 3 is blank; digit 1 is blank.
- **Sequence error.**
  - Stimulus: force sel 0→2 (skip), then resume a normal count.
  - err=1 one edge later and stays 1 until reset; display operation continues.
